// File: rtl/term_pkg.sv
// Shared types, constants and the row-mapping helper for the terminal controller.
package term_pkg;

    localparam int COLS_DEF = 70;
    localparam int ROWS_DEF = 30;

    localparam logic [7:0] ASC_BS = 8'h08;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_SP = 8'h20;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WRITE,
        SCROLL
    } term_state_e;

    // (base + y) mod rows; both operands are already below rows, so one subtract suffices.
    function automatic logic [4:0] phys_row(input logic [4:0] base, input logic [4:0] y,
                                            input int rows);
        logic [5:0] s;
        s = {1'b0, base} + {1'b0, y};
        if (int'(s) >= rows) s = s - 6'(rows);
        return s[4:0];
    endfunction

endpackage

// File: rtl/term_ctrl_if.sv
// Key-event handshake plus character-memory write bus and cursor/status outputs.
interface term_ctrl_if;
    import term_pkg::*;

    // A key moves on every clock edge where key_valid and key_ready are both high;
    // key_data is only looked at on that edge, and the source holds both until then.
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_ready;
    logic        wr_en;
    logic [6:0]  wr_x;
    logic [4:0]  wr_y;
    logic [7:0]  wr_data;
    logic [4:0]  row_base;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        cursor_on;
    term_state_e dbg_state;

    modport master (
        input  key_valid, key_data,
        output key_ready, wr_en, wr_x, wr_y, wr_data, row_base, cur_x, cur_y, cursor_on, dbg_state
    );

    modport slave (
        output key_valid, key_data,
        input  key_ready, wr_en, wr_x, wr_y, wr_data, row_base, cur_x, cur_y, cursor_on, dbg_state
    );

endinterface

// File: rtl/term_blink.sv
// Cursor blink phase generator; restart_i forces the visible phase and restarts the period.
module term_blink #(
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart_i,
    output logic cursor_on_o
);
    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        on_d  = on_q;
        if (restart_i) begin
            cnt_d = '0;
            on_d  = 1'b1;
        end else if (cnt_q == CW'(BLINK_CYCLES - 1)) begin
            cnt_d = '0;
            on_d  = ~on_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            on_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

    assign cursor_on_o = on_q;

endmodule

// File: rtl/term_ctrl.sv
// Terminal controller: screen clear after reset, key-driven cell writes, cursor
// movement and circular-row-base scrolling onto a character memory.
module term_ctrl
    import term_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int BLINK_CYCLES = 12500000
) (
    input logic         clock,
    input logic         reset,
    term_ctrl_if.master bus
);
    term_state_e state_q, state_d;
    logic        run_q, run_d;
    logic [6:0]  cur_x_q, cur_x_d, nx_q, nx_d, wx_q, wx_d, clr_x_q, clr_x_d;
    logic [4:0]  cur_y_q, cur_y_d, ny_q, ny_d, wy_q, wy_d, clr_y_q, clr_y_d;
    logic [4:0]  row_base_q, row_base_d;
    logic [7:0]  wd_q, wd_d;
    logic        we_q, we_d, scroll_q, scroll_d;
    logic        blink_restart;

    logic [7:0]  key;
    logic        is_print, is_nl, is_bs, last_x, last_y;

    assign key      = bus.key_data;
    assign is_print = (key >= 8'h20) && (key <= 8'h7E);
    assign is_nl    = (key == ASC_LF) || (key == ASC_CR);
    assign is_bs    = (key == ASC_BS);
    assign last_x   = (cur_x_q == 7'(COLS - 1));
    assign last_y   = (cur_y_q == 5'(ROWS - 1));

    // A key's write address/data and resulting cursor are captured at acceptance;
    // the cursor is committed when WRITE ends so it moves with the write cycle.
    always_comb begin
        state_d       = state_q;
        run_d         = 1'b1;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        wx_d          = wx_q;
        wy_d          = wy_q;
        wd_d          = wd_q;
        we_d          = we_q;
        scroll_d      = scroll_q;
        clr_x_d       = clr_x_q;
        clr_y_d       = clr_y_q;
        row_base_d    = row_base_q;
        blink_restart = 1'b0;

        case (state_q)
            INIT: begin
                if (run_q) begin
                    if (clr_x_q == 7'(COLS - 1)) begin
                        clr_x_d = '0;
                        if (clr_y_q == 5'(ROWS - 1)) state_d = IDLE;
                        else clr_y_d = clr_y_q + 5'd1;
                    end else begin
                        clr_x_d = clr_x_q + 7'd1;
                    end
                end
            end

            IDLE: begin
                if (bus.key_valid) begin
                    state_d  = WRITE;
                    we_d     = 1'b0;
                    scroll_d = 1'b0;
                    nx_d     = cur_x_q;
                    ny_d     = cur_y_q;
                    wx_d     = cur_x_q;
                    wy_d     = phys_row(row_base_q, cur_y_q, ROWS);
                    wd_d     = key;
                    if (is_print) begin
                        we_d = 1'b1;
                        if (last_x) begin
                            nx_d = '0;
                            if (last_y) scroll_d = 1'b1;
                            else ny_d = cur_y_q + 5'd1;
                        end else begin
                            nx_d = cur_x_q + 7'd1;
                        end
                    end else if (is_nl) begin
                        nx_d = '0;
                        if (!last_y) begin
                            ny_d = cur_y_q + 5'd1;
                        end else begin
                            // Bare newline on the bottom row scrolls straight away.
                            state_d       = SCROLL;
                            cur_x_d       = '0;
                            row_base_d    = phys_row(row_base_q, 5'd1, ROWS);
                            clr_x_d       = '0;
                            clr_y_d       = row_base_q;
                            blink_restart = (cur_x_q != '0);
                        end
                    end else if (is_bs) begin
                        wd_d = ASC_SP;
                        if (cur_x_q != '0) begin
                            we_d = 1'b1;
                            nx_d = cur_x_q - 7'd1;
                            wx_d = cur_x_q - 7'd1;
                        end else if (cur_y_q != '0) begin
                            we_d = 1'b1;
                            nx_d = 7'(COLS - 1);
                            ny_d = cur_y_q - 5'd1;
                            wx_d = 7'(COLS - 1);
                            wy_d = phys_row(row_base_q, cur_y_q - 5'd1, ROWS);
                        end
                    end
                end
            end

            WRITE: begin
                cur_x_d       = nx_q;
                cur_y_d       = ny_q;
                blink_restart = (nx_q != cur_x_q) || (ny_q != cur_y_q);
                if (scroll_q) begin
                    state_d    = SCROLL;
                    row_base_d = phys_row(row_base_q, 5'd1, ROWS);
                    clr_x_d    = '0;
                    clr_y_d    = row_base_q;
                end else begin
                    state_d = IDLE;
                end
            end

            SCROLL: begin
                if (clr_x_q == 7'(COLS - 1)) state_d = IDLE;
                else clr_x_d = clr_x_q + 7'd1;
            end

            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            run_q      <= 1'b0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
            wd_q       <= ASC_SP;
            we_q       <= 1'b0;
            scroll_q   <= 1'b0;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            wd_q       <= wd_d;
            we_q       <= we_d;
            scroll_q   <= scroll_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
            row_base_q <= row_base_d;
        end
    end

    assign bus.key_ready = (state_q == IDLE);
    assign bus.wr_en     = ((state_q == INIT) && run_q) || ((state_q == WRITE) && we_q)
                         || (state_q == SCROLL);
    assign bus.wr_x      = (state_q == WRITE) ? wx_q : clr_x_q;
    assign bus.wr_y      = (state_q == WRITE) ? wy_q : clr_y_q;
    assign bus.wr_data   = (state_q == WRITE) ? wd_q : ASC_SP;
    assign bus.row_base  = row_base_q;
    assign bus.cur_x     = cur_x_q;
    assign bus.cur_y     = cur_y_q;
    assign bus.dbg_state = state_q;

    term_blink #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
        .clock       (clock),
        .reset       (reset),
        .restart_i   (blink_restart),
        .cursor_on_o (bus.cursor_on)
    );

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: a text-screen model predicts every memory write, cursor,
// row base and blink phase; the DUT's writes also rebuild a memory for screen compares.
module tb_term_ctrl;
    import term_pkg::*;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int BLINK = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    term_ctrl_if bus ();

    term_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(BLINK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bref   = 0;
    int ref_at = -1;

    logic [19:0] exp_q[$];
    logic [7:0]  mem[ROWS][COLS];
    logic [7:0]  lines[ROWS][COLS];
    int          mx, my, mrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input int x, input int y, input logic [7:0] d);
        exp_q.push_back({7'(x), 5'(y), d});
    endtask

    task automatic tick();
        logic [19:0] w;
        @(posedge clock);
        #1;
        cyc++;
        if (cyc == ref_at) bref = cyc;
        if (reset) bref = cyc;
        chk("blink", bus.cursor_on, 1 ^ (((cyc - bref) / BLINK) & 1));
        if (bus.wr_en === 1'b1) begin
            chk("wr_vs_ready", bus.key_ready, 0);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", bus.wr_en, 0);
            end else begin
                w = exp_q.pop_front();
                chk("wr_x", bus.wr_x, w[19:13]);
                chk("wr_y", bus.wr_y, w[12:8]);
                chk("wr_data", bus.wr_data, w[7:0]);
            end
            if (bus.wr_x < COLS && bus.wr_y < ROWS) mem[bus.wr_y][bus.wr_x] = bus.wr_data;
        end
    endtask

    task automatic model_newline(output bit sc);
        mx = 0;
        sc = 1'b0;
        if (my < ROWS - 1) begin
            my++;
        end else begin
            sc  = 1'b1;
            mrb = (mrb + 1) % ROWS;
            for (int r = 0; r < ROWS - 1; r++) lines[r] = lines[r + 1];
            for (int x = 0; x < COLS; x++) begin
                lines[ROWS - 1][x] = 8'h20;
                push_w(x, (mrb + ROWS - 1) % ROWS, 8'h20);
            end
        end
    endtask

    task automatic model_key(input logic [7:0] k, output int lat, output bit moved, output bit bare);
        int ox, oy;
        bit sc;
        ox   = mx;
        oy   = my;
        lat  = 1;
        bare = 1'b0;
        if (k >= 8'h20 && k <= 8'h7E) begin
            push_w(mx, (mrb + my) % ROWS, k);
            lines[my][mx] = k;
            if (mx == COLS - 1) begin
                model_newline(sc);
                if (sc) lat = COLS + 1;
            end else begin
                mx++;
            end
        end else if (k == 8'h0A || k == 8'h0D) begin
            model_newline(sc);
            if (sc) begin
                lat  = COLS;
                bare = 1'b1;
            end
        end else if (k == 8'h08) begin
            if (mx > 0 || my > 0) begin
                if (mx > 0) mx--;
                else begin
                    my--;
                    mx = COLS - 1;
                end
                push_w(mx, (mrb + my) % ROWS, 8'h20);
                lines[my][mx] = 8'h20;
            end
        end
        moved = (mx != ox) || (my != oy);
    endtask

    task automatic send_key(input logic [7:0] k);
        int n, lat;
        bit moved, bare;
        n = 0;
        while (bus.key_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("ready_wait", bus.key_ready, 1);
        model_key(k, lat, moved, bare);
        if (moved) ref_at = cyc + (bare ? 1 : 2);
        bus.key_valid = 1'b1;
        bus.key_data  = k;
        tick();
        bus.key_valid = 1'b0;
        bus.key_data  = 8'($urandom);
        chk("ready_after_acc", bus.key_ready, 0);
        n = 0;
        while (bus.key_ready !== 1'b1 && n < COLS + 10) begin
            tick();
            n++;
        end
        chk("busy_cycles", n, lat);
        chk("writes_left", exp_q.size(), 0);
        chk("cur_x", bus.cur_x, mx);
        chk("cur_y", bus.cur_y, my);
        chk("row_base", bus.row_base, mrb);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.key_ready, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_x"}, bus.wr_x, 0);
        chk({tag, "_wr_y"}, bus.wr_y, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 8'h20);
        chk({tag, "_row_base"}, bus.row_base, 0);
        chk({tag, "_cur_x"}, bus.cur_x, 0);
        chk({tag, "_cur_y"}, bus.cur_y, 0);
        chk({tag, "_cursor_on"}, bus.cursor_on, 1);
        chk({tag, "_state"}, bus.dbg_state, INIT);
    endtask

    task automatic do_reset();
        int n;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        exp_q.delete();
        ref_at = -1;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        mx  = 0;
        my  = 0;
        mrb = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                lines[y][x] = 8'h20;
                push_w(x, y, 8'h20);
            end
        n = 0;
        while (bus.key_ready !== 1'b1 && n < ROWS * COLS + 50) begin
            tick();
            n++;
        end
        chk("init_cycles", n, ROWS * COLS + 1);
        chk("init_left", exp_q.size(), 0);
        chk("init_cur_x", bus.cur_x, 0);
        chk("init_cur_y", bus.cur_y, 0);
        chk("init_row_base", bus.row_base, 0);
    endtask

    task automatic check_screen(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int x = 0; x < COLS; x++)
                if (mem[(mrb + r) % ROWS][x] !== lines[r][x]) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        int  lat, sel;
        bit  moved, bare;
        logic [7:0] k;

        bus.key_valid = 1'b0;
        bus.key_data  = 8'h00;

        // Power-up clear.
        do_reset();
        check_screen("screen_init");

        // Two printable keys.
        send_key(8'h41);
        send_key(8'h42);
        chk("ab_cur_x", bus.cur_x, 2);
        chk("ab_cur_y", bus.cur_y, 0);

        // Backspace from column 0 wraps up a row; at home it is a no-op.
        send_key(ASC_LF);
        send_key(ASC_BS);
        chk("bs_wrap_x", bus.cur_x, COLS - 1);
        chk("bs_wrap_y", bus.cur_y, 0);
        while (mx != 0 || my != 0) send_key(ASC_BS);
        send_key(ASC_BS);
        chk("bs_home_x", bus.cur_x, 0);
        chk("bs_home_y", bus.cur_y, 0);

        // Idle period lets the blink phase toggle a few times.
        repeat (3 * BLINK) tick();
        check_screen("screen_directed");

        // Random key stream.
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 60) k = 8'($urandom_range(32, 126));
            else if (sel < 75) k = ($urandom_range(0, 1) == 0) ? ASC_LF : ASC_CR;
            else if (sel < 90) k = ASC_BS;
            else k = 8'($urandom_range(0, 255));
            send_key(k);
        end
        check_screen("screen_random");

        // Wrap on the bottom-right cell scrolls.
        do_reset();
        repeat (ROWS - 1) send_key(ASC_LF);
        repeat (COLS - 1) send_key(8'($urandom_range(33, 126)));
        chk("pre_z_x", bus.cur_x, COLS - 1);
        chk("pre_z_y", bus.cur_y, ROWS - 1);
        send_key(8'h5A);
        chk("z_row_base", bus.row_base, 1);
        chk("z_cur_x", bus.cur_x, 0);
        chk("z_cur_y", bus.cur_y, ROWS - 1);
        chk("z_cell", mem[ROWS - 1][COLS - 1], 8'h5A);

        // Row base wraps round; writes land on the mapped physical row.
        repeat (ROWS - 2) send_key(ASC_LF);
        chk("rb_29", bus.row_base, 29);
        while (!(mx == 5 && my == 3)) send_key(ASC_BS);
        send_key(8'h51);
        chk("q_cell", mem[2][5], 8'h51);
        check_screen("screen_scrolled");

        // Reset in the middle of a scroll clear.
        while (my != ROWS - 1) send_key(ASC_LF);
        model_key(ASC_LF, lat, moved, bare);
        bus.key_valid = 1'b1;
        bus.key_data  = ASC_LF;
        tick();
        bus.key_valid = 1'b0;
        repeat (30) tick();
        chk("mid_scroll_en", bus.wr_en, 1);
        chk("mid_scroll_x", bus.wr_x, 30);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("async");
        do_reset();
        check_screen("screen_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
